// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter: shares the single ULPI register-access port among
// NUM_REQ requesters with round-robin arbitration. One transaction is in
// flight at a time. PHY FAIL strobes and timeouts are retried up to
// MAX_RETRY times. Each transaction ends with a one-cycle done or error
// pulse on the owning requester's bit.
module ulpi_reg_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 3,
    parameter int TO_CYCLES = 200
) (
    input  logic                   CLK_60M,
    input  logic                   RST_A_USB,
    input  logic [NUM_REQ-1:0]     REQ_EN,
    input  logic [NUM_REQ-1:0]     REQ_RW,
    input  logic [6*NUM_REQ-1:0]   REQ_ADDR,
    input  logic [8*NUM_REQ-1:0]   REQ_DATA_I,
    output logic [7:0]             REQ_DATA_O,
    output logic [NUM_REQ-1:0]     REQ_DONE,
    output logic [NUM_REQ-1:0]     REQ_ERR,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic                   BUSY,
    input  logic                   READY,
    output logic                   REG_EN,
    output logic                   REG_RW,
    output logic [5:0]             REG_ADDR,
    output logic [7:0]             REG_DATA_I,
    input  logic [7:0]             REG_DATA_O,
    input  logic                   REG_DONE,
    input  logic                   REG_FAIL
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [7:0]       TO_LAST    = 8'(TO_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state_q,     state_d;
    logic [IDX_W-1:0]   lastGrant_q, lastGrant_d;
    logic [7:0]         retryCnt_q,  retryCnt_d;
    logic [7:0]         timer_q,     timer_d;
    logic [NUM_REQ-1:0] grant_q,     grant_d;
    logic [NUM_REQ-1:0] reqDone_q,   reqDone_d;
    logic [NUM_REQ-1:0] reqErr_q,    reqErr_d;
    logic [7:0]         reqDataO_q,  reqDataO_d;
    logic               busy_q,      busy_d;
    logic               regEn_q,     regEn_d;
    logic               regRw_q,     regRw_d;
    logic [5:0]         regAddr_q,   regAddr_d;
    logic [7:0]         regDataI_q,  regDataI_d;

    logic               pickValid;
    logic [IDX_W-1:0]   pickIdx;
    logic [IDX_W-1:0]   candIdx;
    logic [NUM_REQ-1:0] pickOneHot;
    logic               pickRw;
    logic [5:0]         pickAddr;
    logic [7:0]         pickData;

    // Round-robin search: the first active request after the last owner,
    // wrapping around. The loop runs from the farthest offset down so that
    // the nearest offset overwrites and wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        candIdx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            candIdx = IDX_W'((int'(lastGrant_q) + i) % NUM_REQ);
            if (REQ_EN[candIdx]) begin
                pickValid = 1'b1;
                pickIdx   = candIdx;
            end
        end
    end

    // Select the chosen requester's transaction fields and its one-hot grant.
    always_comb begin
        pickOneHot = '0;
        pickRw     = 1'b0;
        pickAddr   = '0;
        pickData   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickIdx == IDX_W'(i)) begin
                pickOneHot[i] = 1'b1;
                pickRw        = REQ_RW[i];
                pickAddr      = REQ_ADDR[6*i +: 6];
                pickData      = REQ_DATA_I[8*i +: 8];
            end
        end
    end

    // Transaction FSM. Every output is computed one cycle ahead here, so it
    // comes straight from a flop. REG_EN and the response pulses default
    // low and are raised only on the transition into ISSUE or RESP.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        retryCnt_d  = retryCnt_q;
        timer_d     = timer_q;
        grant_d     = grant_q;
        reqDone_d   = '0;
        reqErr_d    = '0;
        reqDataO_d  = reqDataO_q;
        busy_d      = busy_q;
        regEn_d     = 1'b0;
        regRw_d     = regRw_q;
        regAddr_d   = regAddr_q;
        regDataI_d  = regDataI_q;
        case (state_q)
            ST_IDLE: begin
                if (READY && pickValid) begin
                    regRw_d     = pickRw;
                    regAddr_d   = pickAddr;
                    regDataI_d  = pickData;
                    grant_d     = pickOneHot;
                    lastGrant_d = pickIdx;
                    retryCnt_d  = '0;
                    regEn_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (REG_DONE) begin
                    reqDataO_d = REG_DATA_O;
                    reqDone_d  = grant_q;
                    state_d    = ST_RESP;
                end else if (!READY) begin
                    reqErr_d = grant_q;
                    state_d  = ST_RESP;
                end else if (REG_FAIL || (timer_q == TO_LAST)) begin
                    if (retryCnt_q < RETRY_MAX) begin
                        retryCnt_d = retryCnt_q + 8'd1;
                        regEn_d    = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        reqErr_d = grant_q;
                        state_d  = ST_RESP;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction silently.
    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= LAST_RESET;
            retryCnt_q  <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            reqDone_q   <= '0;
            reqErr_q    <= '0;
            reqDataO_q  <= '0;
            busy_q      <= 1'b0;
            regEn_q     <= 1'b0;
            regRw_q     <= 1'b0;
            regAddr_q   <= '0;
            regDataI_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            retryCnt_q  <= retryCnt_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            reqDone_q   <= reqDone_d;
            reqErr_q    <= reqErr_d;
            reqDataO_q  <= reqDataO_d;
            busy_q      <= busy_d;
            regEn_q     <= regEn_d;
            regRw_q     <= regRw_d;
            regAddr_q   <= regAddr_d;
            regDataI_q  <= regDataI_d;
        end
    end

    assign REQ_DATA_O = reqDataO_q;
    assign REQ_DONE   = reqDone_q;
    assign REQ_ERR    = reqErr_q;
    assign GRANT      = grant_q;
    assign BUSY       = busy_q;
    assign REG_EN     = regEn_q;
    assign REG_RW     = regRw_q;
    assign REG_ADDR   = regAddr_q;
    assign REG_DATA_I = regDataI_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// tb_ulpi_reg_arbiter: scoreboard bench for ulpi_reg_arbiter. Each test
// queues the transactions and responses it expects, plus a script of PHY
// reactions. A single per-cycle tick compares DUT activity against the
// queues, plays the PHY script, and models requesters dropping REQ_EN.
module tb_ulpi_reg_arbiter;

    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_FAIL = 2;

    typedef struct {
        int         kind;
        int         delay;
        logic [7:0] data;
    } phyStep_t;

    logic        CLK_60M = 1'b0;
    logic        RST_A_USB;
    logic [3:0]  REQ_EN;
    logic [3:0]  REQ_RW;
    logic [23:0] REQ_ADDR;
    logic [31:0] REQ_DATA_I;
    logic [7:0]  REQ_DATA_O;
    logic [3:0]  REQ_DONE;
    logic [3:0]  REQ_ERR;
    logic [3:0]  GRANT;
    logic        BUSY;
    logic        READY;
    logic        REG_EN;
    logic        REG_RW;
    logic [5:0]  REG_ADDR;
    logic [7:0]  REG_DATA_I;
    logic [7:0]  REG_DATA_O;
    logic        REG_DONE;
    logic        REG_FAIL;

    int testCount = 0;
    int failCount = 0;
    int cycle = 0;
    int repeatCnt[4];
    logic [31:0] expIssue[$];
    logic [31:0] expResp[$];
    phyStep_t    phyScript[$];
    int          enCycles[$];
    bit          prevResp = 1'b0;
    bit          phyActive = 1'b0;
    int          phyCount = 0;
    int          phyKind = 0;
    logic [7:0]  phyData = 8'h00;

    ulpi_reg_arbiter #(.NUM_REQ(4), .MAX_RETRY(3), .TO_CYCLES(200)) dut (
        .CLK_60M    (CLK_60M),
        .RST_A_USB  (RST_A_USB),
        .REQ_EN     (REQ_EN),
        .REQ_RW     (REQ_RW),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_DATA_I (REQ_DATA_I),
        .REQ_DATA_O (REQ_DATA_O),
        .REQ_DONE   (REQ_DONE),
        .REQ_ERR    (REQ_ERR),
        .GRANT      (GRANT),
        .BUSY       (BUSY),
        .READY      (READY),
        .REG_EN     (REG_EN),
        .REG_RW     (REG_RW),
        .REG_ADDR   (REG_ADDR),
        .REG_DATA_I (REG_DATA_I),
        .REG_DATA_O (REG_DATA_O),
        .REG_DONE   (REG_DONE),
        .REG_FAIL   (REG_FAIL)
    );

    // 60 MHz PHY clock, roughly 16 ns period.
    initial forever #8 CLK_60M = ~CLK_60M;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic rw, input logic [5:0] addr,
                                 input logic [7:0] data, input int reps);
        REQ_RW[idx]           = rw;
        REQ_ADDR[idx*6 +: 6]  = addr;
        REQ_DATA_I[idx*8 +: 8] = data;
        repeatCnt[idx]        = reps;
        REQ_EN[idx]           = 1'b1;
    endtask

    task automatic pushIssue(input int idx);
        logic [3:0] g;
        g = 4'b0001 << idx;
        expIssue.push_back({13'b0, g, REQ_RW[idx], REQ_ADDR[idx*6 +: 6], REQ_DATA_I[idx*8 +: 8]});
    endtask

    task automatic pushResp(input logic [3:0] done, input logic [3:0] err, input logic [7:0] data);
        expResp.push_back({16'b0, done, err, data});
    endtask

    task automatic pushPhy(input int kind, input int delay, input logic [7:0] data);
        phyStep_t s;
        s.kind  = kind;
        s.delay = delay;
        s.data  = data;
        phyScript.push_back(s);
    endtask

    // One clock cycle: sample outputs on the falling edge, score them,
    // advance the PHY model and let finished requesters drop REQ_EN.
    task automatic tick();
        logic [31:0] e;
        phyStep_t    s;
        @(negedge CLK_60M);
        cycle++;
        if (prevResp)
            checkOutput("idle_after_resp", 32'({GRANT, BUSY}), 32'd0);
        if (REG_EN) begin
            enCycles.push_back(cycle);
            if (expIssue.size() == 0) begin
                checkOutput("unexpected_issue", 32'd1, 32'd0);
            end else begin
                e = expIssue.pop_front();
                checkOutput("issue", {13'b0, GRANT, REG_RW, REG_ADDR, REG_DATA_I}, e);
            end
        end
        if ((REQ_DONE | REQ_ERR) != 4'b0) begin
            if (expResp.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = expResp.pop_front();
                checkOutput("resp", {16'b0, REQ_DONE, REQ_ERR, REQ_DATA_O}, e);
            end
        end
        prevResp = ((REQ_DONE | REQ_ERR) != 4'b0);

        REG_DONE = 1'b0;
        REG_FAIL = 1'b0;
        if (phyActive) begin
            phyCount--;
            if (phyCount == 0) begin
                phyActive = 1'b0;
                if (phyKind == K_DONE) begin
                    REG_DONE   = 1'b1;
                    REG_DATA_O = phyData;
                end else begin
                    REG_FAIL   = 1'b1;
                    REG_DATA_O = 8'hEE;
                end
            end
        end
        if (REG_EN && phyScript.size() > 0) begin
            s = phyScript.pop_front();
            if (s.kind != K_NONE) begin
                phyActive = 1'b1;
                phyCount  = s.delay;
                phyKind   = s.kind;
                phyData   = s.data;
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (REQ_DONE[i] || REQ_ERR[i]) begin
                if (repeatCnt[i] > 0) repeatCnt[i]--;
                else REQ_EN[i] = 1'b0;
            end
        end
    endtask

    task automatic waitDone(input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            tick();
            n++;
            ok = (expIssue.size() == 0) && (expResp.size() == 0) && !BUSY;
        end
        if (!ok) checkOutput("timeout", 32'd1, 32'd0);
    endtask

    task automatic waitRegEn(input int budget);
        int n;
        n = 0;
        tick();
        while (!REG_EN && n < budget) begin
            tick();
            n++;
        end
        if (!REG_EN) checkOutput("reg_en_wait", 32'd0, 32'd1);
    endtask

    initial begin
        RST_A_USB  = 1'b1;
        READY      = 1'b1;
        REQ_EN     = '0;
        REQ_RW     = '0;
        REQ_ADDR   = '0;
        REQ_DATA_I = '0;
        REG_DATA_O = '0;
        REG_DONE   = 1'b0;
        REG_FAIL   = 1'b0;
        for (int i = 0; i < 4; i++) repeatCnt[i] = 0;

        // Reset values
        tick(); tick();
        checkOutput("reset_outputs", 32'({REG_EN, REG_RW, REG_ADDR, REG_DATA_I, GRANT, BUSY, REQ_DONE, REQ_ERR}), 32'd0);
        checkOutput("reset_data_o", 32'(REQ_DATA_O), 32'd0);
        RST_A_USB = 1'b0;
        tick();

        // All four requesting: round-robin order 0,1,2,3,0,1 from reset
        $display("[TB] round-robin with all four requesters");
        for (int i = 0; i < 4; i++)
            applyStimulus(i, i[0], 6'(6'h20 + i), 8'(8'hA0 + i), (i < 2) ? 1 : 0);
        for (int n = 0; n < 6; n++) begin
            pushIssue(n % 4);
            pushPhy(K_DONE, 1, 8'(8'h30 + n));
            pushResp(4'(4'b0001 << (n % 4)), 4'b0, 8'(8'h30 + n));
        end
        waitDone(200);

        // Req0 write, PHY done after 5 cycles; write completion still latches data
        $display("[TB] single write");
        enCycles.delete();
        applyStimulus(0, 1'b1, 6'h16, 8'h5A, 0);
        pushIssue(0);
        pushPhy(K_DONE, 5, 8'h77);
        pushResp(4'b0001, 4'b0, 8'h77);
        waitDone(100);
        checkOutput("write_en_pulses", 32'(enCycles.size()), 32'd1);

        // Req1 read returns 0x06 and holds afterwards
        $display("[TB] single read");
        applyStimulus(1, 1'b0, 6'h0A, 8'h00, 0);
        pushIssue(1);
        pushPhy(K_DONE, 2, 8'h06);
        pushResp(4'b0010, 4'b0, 8'h06);
        waitDone(100);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("data_hold", 32'(REQ_DATA_O), 32'h06);

        // Req2: two FAILs then DONE
        $display("[TB] retry then success");
        enCycles.delete();
        applyStimulus(2, 1'b1, 6'h2B, 8'hC3, 0);
        for (int i = 0; i < 3; i++) pushIssue(2);
        pushPhy(K_FAIL, 1, 8'h00);
        pushPhy(K_FAIL, 3, 8'h00);
        pushPhy(K_DONE, 2, 8'h99);
        pushResp(4'b0100, 4'b0, 8'h99);
        waitDone(200);
        checkOutput("retry_ok_pulses", 32'(enCycles.size()), 32'd3);

        // Req2: FAIL on every attempt exhausts retries
        $display("[TB] retries exhausted");
        enCycles.delete();
        applyStimulus(2, 1'b1, 6'h2B, 8'hC3, 0);
        for (int i = 0; i < 4; i++) begin
            pushIssue(2);
            pushPhy(K_FAIL, i + 1, 8'h00);
        end
        pushResp(4'b0, 4'b0100, 8'h99);
        waitDone(200);
        checkOutput("retry_err_pulses", 32'(enCycles.size()), 32'd4);

        // Req3: no PHY response at all, timeout per attempt
        $display("[TB] timeout retries");
        enCycles.delete();
        applyStimulus(3, 1'b0, 6'h11, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            pushIssue(3);
            pushPhy(K_NONE, 0, 8'h00);
        end
        pushResp(4'b0, 4'b1000, 8'h99);
        waitDone(2000);
        checkOutput("timeout_pulses", 32'(enCycles.size()), 32'd4);
        for (int i = 1; i < enCycles.size(); i++)
            checkOutput("timeout_spacing", 32'(enCycles[i] - enCycles[i-1]), 32'd201);

        // READY dropped during WAIT aborts with no retry
        $display("[TB] ready drop in wait");
        enCycles.delete();
        applyStimulus(0, 1'b0, 6'h3F, 8'h00, 0);
        pushIssue(0);
        pushPhy(K_NONE, 0, 8'h00);
        pushResp(4'b0, 4'b0001, 8'h99);
        waitRegEn(20);
        tick(); tick(); tick();
        READY = 1'b0;
        tick();
        checkOutput("ready_abort_err", 32'(REQ_ERR), 32'b0001);
        waitDone(50);
        checkOutput("ready_abort_pulses", 32'(enCycles.size()), 32'd1);

        // READY low in IDLE: no grant until it returns
        $display("[TB] ready low in idle");
        enCycles.delete();
        applyStimulus(1, 1'b1, 6'h05, 8'h3C, 0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("ready_low_no_issue", 32'(enCycles.size()), 32'd0);
        checkOutput("ready_low_idle", 32'({GRANT, BUSY}), 32'd0);
        pushIssue(1);
        pushPhy(K_DONE, 1, 8'h5C);
        pushResp(4'b0010, 4'b0, 8'h5C);
        READY = 1'b1;
        waitDone(50);

        // Async reset during WAIT, then pending 1010 grants requester 1 first
        $display("[TB] reset during wait");
        applyStimulus(2, 1'b0, 6'h05, 8'h00, 0);
        pushIssue(2);
        pushPhy(K_NONE, 0, 8'h00);
        waitRegEn(20);
        tick(); tick();
        #2 RST_A_USB = 1'b1;
        #1;
        checkOutput("async_reset_outputs", 32'({REG_EN, REG_RW, REG_ADDR, REG_DATA_I, GRANT, BUSY, REQ_DONE, REQ_ERR}), 32'd0);
        checkOutput("async_reset_data_o", 32'(REQ_DATA_O), 32'd0);
        REQ_EN = 4'b0000;
        phyScript.delete();
        applyStimulus(1, 1'b1, 6'h21, 8'h81, 0);
        applyStimulus(3, 1'b0, 6'h23, 8'h83, 0);
        tick(); tick();
        pushIssue(1);
        pushPhy(K_DONE, 1, 8'h41);
        pushResp(4'b0010, 4'b0, 8'h41);
        pushIssue(3);
        pushPhy(K_DONE, 1, 8'h43);
        pushResp(4'b1000, 4'b0, 8'h43);
        RST_A_USB = 1'b0;
        waitDone(100);

        checkOutput("issue_queue_empty", 32'(expIssue.size()), 32'd0);
        checkOutput("resp_queue_empty", 32'(expResp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
